// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    localparam int DATA_WIDTH_C    = 32;
    localparam int ADDRESS_WIDTH_C = 16;
    localparam int FIFO_DEPTH_C    = 4;
    localparam int PC_INCR         = 4;
    localparam int CNT_W           = $clog2(FIFO_DEPTH_C) + 1;

    typedef struct packed {
        logic [DATA_WIDTH_C-1:0]    instr;
        logic [ADDRESS_WIDTH_C-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {S_RESET, S_RUN} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetched words; flush beats push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_C,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Push into a full buffer is only legal alongside a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        push |-> (!full || pop));
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word reads, buffers responses for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_C,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_C,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_C,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t             state, state_n;
    logic [ADDRESS_WIDTH-1:0] fetch_pc, resp_pc;
    logic [CW-1:0]            live_cnt, stale_cnt, fifo_count;
    logic                     fifo_full, fifo_empty;
    logic                     grant, accept, drop_stale, drop_any;
    logic [CW:0]              occ, inflight;
    fetch_entry_t             push_entry, head;

    always_ff @(posedge clk) begin
        if (rst) state <= S_RESET;
        else     state <= state_n;
    end

    // Draining stale responses is counter-based, so RUN is the only operating state.
    always_comb begin
        state_n = state;
        case (state)
            S_RESET: state_n = S_RUN;
            S_RUN:   state_n = S_RUN;
            default: state_n = S_RESET;
        endcase
    end

    // Buffer slots are reserved for every live request; stale ones only hold issue credits.
    assign occ      = {1'b0, fifo_count} + {1'b0, live_cnt};
    assign inflight = {1'b0, live_cnt} + {1'b0, stale_cnt};
    assign mem_req  = !rst && !redirect && (occ < (CW+1)'(FIFO_DEPTH))
                      && (inflight < (CW+1)'(FIFO_DEPTH));
    assign mem_addr = fetch_pc;

    assign grant      = mem_req && mem_gnt;
    assign drop_stale = mem_rvalid && (stale_cnt != '0);
    assign drop_any   = mem_rvalid && ((stale_cnt != '0) || (live_cnt != '0));
    assign accept     = mem_rvalid && (stale_cnt == '0) && (live_cnt != '0) && !redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            live_cnt  <= '0;
            stale_cnt <= '0;
        end else if (redirect) begin
            fetch_pc  <= redirect_pc & ~ADDRESS_WIDTH'(3);
            resp_pc   <= redirect_pc & ~ADDRESS_WIDTH'(3);
            live_cnt  <= '0;
            stale_cnt <= stale_cnt + live_cnt - CW'(drop_any);
        end else begin
            if (grant)  fetch_pc <= fetch_pc + ADDRESS_WIDTH'(PC_INCR);
            if (accept) resp_pc  <= resp_pc + ADDRESS_WIDTH'(PC_INCR);
            live_cnt  <= live_cnt + CW'(grant) - CW'(accept);
            stale_cnt <= stale_cnt - CW'(drop_stale);
        end
    end

    assign push_entry.instr = mem_rdata;
    assign push_entry.pc    = resp_pc;

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_entry),
        .pop       (instr_valid && instr_ready),
        .flush     (redirect),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign instr_valid = !rst && !fifo_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        !(mem_rvalid && live_cnt == '0 && stale_cnt == '0));
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based model of outstanding requests.
module tb_fetch_unit;
    localparam int D = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [15:0] mem_addr, instr_pc, redirect_pc = '0;
    logic [31:0] mem_rdata = '0, instr;
    logic        instr_valid, instr_ready = 1'b0, redirect = 1'b0;
    logic        w_req, w_valid;
    logic [15:0] w_addr, w_pc;
    logic [31:0] w_instr;

    always #5 clk = ~clk;

    fetch_unit #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // Second instance: reset PC near the top of the address space, memory never answers.
    fetch_unit #(.FIFO_DEPTH(D), .RESET_PC(16'hFFF8)) dut_w (
        .clk(clk), .rst(rst), .mem_req(w_req), .mem_addr(w_addr), .mem_gnt(1'b1),
        .mem_rvalid(1'b0), .mem_rdata(32'h0), .instr_valid(w_valid),
        .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_pc),
        .redirect(1'b0), .redirect_pc(16'h0)
    );

    int nvec = 0, nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a} ^ 32'h1357_9BDF;
    endfunction

    typedef struct { logic [15:0] addr; int due; } mreq_t;
    typedef struct { logic [15:0] pc; bit want; } oreq_t;
    typedef struct { logic [31:0] ins; logic [15:0] pc; } ent_t;

    mreq_t       mq[$];   // memory environment: granted requests awaiting a response
    oreq_t       oq[$];   // model: outstanding requests, want=0 once a redirect orphans them
    ent_t        fq[$];   // model: instruction buffer as seen by decode
    logic [15:0] fpc;
    logic [15:0] wexp[4];

    initial begin
        int   lat, nw;
        bit   exp_req, exp_valid, have;
        oreq_t o;
        ent_t  ne;
        wexp = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
        fpc  = '0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            rst = (cyc < 3) || (cyc >= 900 && cyc < 902) || (cyc > 100 && $urandom_range(0, 499) == 0);
            if (cyc < 45) begin
                mem_gnt = 1'b1; instr_ready = 1'b1; redirect = 1'b0; lat = 0;
            end else if (cyc < 65) begin
                mem_gnt = 1'b1; instr_ready = (cyc >= 55); redirect = 1'b0; lat = 0;
            end else begin
                mem_gnt     = ($urandom_range(0, 3) != 0);
                instr_ready = ($urandom_range(0, 3) != 0);
                redirect    = ($urandom_range(0, 9) == 0);
                lat         = 3;
            end
            redirect_pc = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                                      : 16'($urandom);
            mem_rvalid = !rst && mq.size() > 0 && mq[0].due <= cyc;
            mem_rdata  = mem_rvalid ? memf(mq[0].addr) : $urandom;
            #1;

            nw = 0;
            foreach (oq[i]) if (oq[i].want) nw++;
            exp_req   = !rst && !redirect && (fq.size() + nw < D) && (oq.size() < D);
            exp_valid = !rst && fq.size() > 0;
            check("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req && mem_req) check("mem_addr", 32'(mem_addr), 32'(fpc));
            check("instr_valid", 32'(instr_valid), 32'(exp_valid));
            if (exp_valid && instr_valid) begin
                check("instr", instr, fq[0].ins);
                check("instr_pc", 32'(instr_pc), 32'(fq[0].pc));
            end
            if (cyc >= 3 && cyc <= 6) begin
                check("wrap_req", 32'(w_req), 32'd1);
                check("wrap_addr", 32'(w_addr), 32'(wexp[cyc-3]));
            end
            if (cyc == 7) check("wrap_req_stop", 32'(w_req), 32'd0);
            if (cyc >= 3 && cyc <= 7) check("wrap_valid", 32'(w_valid), 32'd0);

            // Memory environment follows what the DUT actually requested.
            if (rst) mq.delete();
            else begin
                if (mem_rvalid) void'(mq.pop_front());
                if (mem_req && mem_gnt)
                    mq.push_back('{addr: mem_addr, due: cyc + 1 + int'($urandom_range(0, lat))});
            end

            // Reference model update for the coming clock edge.
            if (rst) begin
                oq.delete(); fq.delete(); fpc = '0;
            end else begin
                have = 1'b0;
                if (mem_rvalid && oq.size() > 0) begin
                    o = oq.pop_front();
                    if (o.want && !redirect) begin
                        have = 1'b1;
                        ne = '{ins: memf(o.pc), pc: o.pc};
                    end
                end
                if (exp_valid && instr_ready) void'(fq.pop_front());
                if (redirect) begin
                    fq.delete();
                    foreach (oq[i]) oq[i].want = 1'b0;
                    fpc = redirect_pc & 16'hFFFC;
                end else begin
                    if (have) fq.push_back(ne);
                    if (exp_req && mem_gnt) begin
                        oq.push_back('{pc: fpc, want: 1'b1});
                        fpc = fpc + 16'd4;
                    end
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
